// File: rtl/dsa_sched_pkg.sv
// Shared types and tile geometry for the DSA tile scheduler.
// Optional perf counters are enabled with DSA_SCHED_PERF_EN.
package dsa_sched_pkg;
  localparam int SCHED_REG_W  = 32;
  localparam int SCHED_DIM_W  = 16;
  localparam int SCHED_TILE_M = 8;
  localparam int SCHED_TILE_N = 8;
  localparam int TILE_M_LOG2  = $clog2(SCHED_TILE_M);
  localparam int TILE_N_LOG2  = $clog2(SCHED_TILE_N);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_e;

  typedef struct packed {
    logic [SCHED_REG_W-1:0] a_addr;
    logic [SCHED_REG_W-1:0] b_addr;
    logic [SCHED_REG_W-1:0] c_addr;
    logic [SCHED_DIM_W-1:0] rows;
    logic [SCHED_DIM_W-1:0] cols;
    logic [SCHED_DIM_W-1:0] k;
    logic                   a16;
    logic                   last;
  } tile_cmd_t;
endpackage

// File: rtl/dsa_tile_scheduler_if.sv
// Tile command channel between the scheduler (master) and the systolic array (slave).
interface dsa_tile_scheduler_if #(
  parameter int REG_WIDTH = 32,
  parameter int DIM_W     = 16
);
  logic                 tile_valid;
  logic                 tile_ready;
  logic [REG_WIDTH-1:0] tile_a_addr;
  logic [REG_WIDTH-1:0] tile_b_addr;
  logic [REG_WIDTH-1:0] tile_c_addr;
  logic [DIM_W-1:0]     tile_rows;
  logic [DIM_W-1:0]     tile_cols;
  logic [DIM_W-1:0]     tile_k;
  logic                 tile_a16;
  logic                 tile_last;
  logic                 tile_done;

  modport master (
    output tile_valid, tile_a_addr, tile_b_addr, tile_c_addr,
           tile_rows, tile_cols, tile_k, tile_a16, tile_last,
    input  tile_ready, tile_done
  );
  modport slave (
    input  tile_valid, tile_a_addr, tile_b_addr, tile_c_addr,
           tile_rows, tile_cols, tile_k, tile_a16, tile_last,
    output tile_ready, tile_done
  );
endinterface

// File: rtl/dsa_tile_addr_gen.sv
// A/B/C tile pointer walker: strides are pre-shifted at load so stepping is adds only.
module dsa_tile_addr_gen
  import dsa_sched_pkg::*;
#(
  parameter int REG_WIDTH = SCHED_REG_W,
  parameter int TILE_N    = SCHED_TILE_N,
  parameter int M_LOG2    = TILE_M_LOG2,
  parameter int N_LOG2    = TILE_N_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step_col,
  input  logic                 i_step_row,
  input  logic [REG_WIDTH-1:0] i_a_base,
  input  logic [REG_WIDTH-1:0] i_b_base,
  input  logic [REG_WIDTH-1:0] i_c_base,
  input  logic [REG_WIDTH-1:0] i_a_stride,
  input  logic [REG_WIDTH-1:0] i_b_stride,
  input  logic [REG_WIDTH-1:0] i_c_stride,
  output logic [REG_WIDTH-1:0] o_a_ptr,
  output logic [REG_WIDTH-1:0] o_b_ptr,
  output logic [REG_WIDTH-1:0] o_c_ptr
);
  localparam logic [REG_WIDTH-1:0] C_COL_STEP = REG_WIDTH'(TILE_N);

  logic [REG_WIDTH-1:0] r_a_step, r_b_step, r_c_step, r_b_base;
  logic [REG_WIDTH-1:0] r_a_row, r_b_ptr, r_c_row, r_c_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_step <= '0;
      r_b_step <= '0;
      r_c_step <= '0;
      r_b_base <= '0;
      r_a_row  <= '0;
      r_b_ptr  <= '0;
      r_c_row  <= '0;
      r_c_ptr  <= '0;
    end else if (i_load) begin
      r_a_step <= i_a_stride << M_LOG2;
      r_b_step <= i_b_stride << N_LOG2;
      r_c_step <= i_c_stride << M_LOG2;
      r_b_base <= i_b_base;
      r_a_row  <= i_a_base;
      r_b_ptr  <= i_b_base;
      r_c_row  <= i_c_base;
      r_c_ptr  <= i_c_base;
    end else if (i_step_row) begin
      // new tile row restarts B at its base and C at the new row start
      r_a_row <= r_a_row + r_a_step;
      r_c_row <= r_c_row + r_c_step;
      r_c_ptr <= r_c_row + r_c_step;
      r_b_ptr <= r_b_base;
    end else if (i_step_col) begin
      r_b_ptr <= r_b_ptr + r_b_step;
      r_c_ptr <= r_c_ptr + C_COL_STEP;
    end
  end

  assign o_a_ptr = r_a_row;
  assign o_b_ptr = r_b_ptr;
  assign o_c_ptr = r_c_ptr;
endmodule

// File: rtl/dsa_tile_scheduler.sv
// Walks an MxN matmul as TILE_MxTILE_N tiles (n inner, m outer) and issues them to the SA.
// Define DSA_SCHED_PERF_EN to add the perf_cycles/perf_tiles counters.
module dsa_tile_scheduler
  import dsa_sched_pkg::*;
#(
  parameter int REG_WIDTH = SCHED_REG_W,
  parameter int DIM_W     = SCHED_DIM_W,
  parameter int TILE_M    = SCHED_TILE_M,
  parameter int TILE_N    = SCHED_TILE_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 calc_start,
  input  logic                 cfg_16bits_ia,
  input  logic [REG_WIDTH-1:0] dst_base,
  input  logic [REG_WIDTH-1:0] a_base,
  input  logic [REG_WIDTH-1:0] b_base,
  input  logic [REG_WIDTH-1:0] a_stride,
  input  logic [REG_WIDTH-1:0] b_stride,
  input  logic [REG_WIDTH-1:0] c_stride,
  input  logic [DIM_W-1:0]     cfg_m,
  input  logic [DIM_W-1:0]     cfg_n,
  input  logic [DIM_W-1:0]     cfg_k,
  output logic                 sa_ready,
  output logic                 job_done,
  output logic                 job_err,
`ifdef DSA_SCHED_PERF_EN
  output logic [31:0]          perf_cycles,
  output logic [15:0]          perf_tiles,
`endif
  dsa_tile_scheduler_if.master tile
);
  localparam logic [DIM_W-1:0] W_TM = DIM_W'(TILE_M);
  localparam logic [DIM_W-1:0] W_TN = DIM_W'(TILE_N);

  sched_state_e         r_state;
  logic [DIM_W-1:0]     r_m, r_n, r_k, r_m_idx, r_n_idx;
  logic                 r_a16, r_valid, r_sa_ready, r_job_done, r_job_err;
  logic [REG_WIDTH-1:0] w_a_ptr, w_b_ptr, w_c_ptr;
  logic [DIM_W-1:0]     w_m_rem, w_n_rem;
  logic [DIM_W:0]       w_m_end, w_n_end;
  logic                 w_start, w_zero, w_last_row, w_last_col, w_last;
  logic                 w_step_col, w_step_row, w_tile_end;
  tile_cmd_t            w_cmd;

  assign w_start    = calc_start && (r_state == IDLE);
  assign w_zero     = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
  assign w_m_rem    = r_m - r_m_idx;
  assign w_n_rem    = r_n - r_n_idx;
  // one extra bit so index+tile never wraps near the top of the dim range
  assign w_m_end    = {1'b0, r_m_idx} + {1'b0, W_TM};
  assign w_n_end    = {1'b0, r_n_idx} + {1'b0, W_TN};
  assign w_last_row = w_m_end >= {1'b0, r_m};
  assign w_last_col = w_n_end >= {1'b0, r_n};
  assign w_last     = w_last_row && w_last_col;
  assign w_tile_end = (r_state == WAIT) && tile.tile_done && !w_last;
  assign w_step_col = w_tile_end && !w_last_col;
  assign w_step_row = w_tile_end && w_last_col;

  dsa_tile_addr_gen #(
    .REG_WIDTH (REG_WIDTH),
    .TILE_N    (TILE_N),
    .M_LOG2    ($clog2(TILE_M)),
    .N_LOG2    ($clog2(TILE_N))
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_step_col (w_step_col),
    .i_step_row (w_step_row),
    .i_a_base   (a_base),
    .i_b_base   (b_base),
    .i_c_base   (dst_base),
    .i_a_stride (a_stride),
    .i_b_stride (b_stride),
    .i_c_stride (c_stride),
    .o_a_ptr    (w_a_ptr),
    .o_b_ptr    (w_b_ptr),
    .o_c_ptr    (w_c_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_m        <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_m_idx    <= '0;
      r_n_idx    <= '0;
      r_a16      <= 1'b0;
      r_valid    <= 1'b0;
      r_sa_ready <= 1'b1;
      r_job_done <= 1'b0;
      r_job_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (calc_start) begin
          r_m        <= cfg_m;
          r_n        <= cfg_n;
          r_k        <= cfg_k;
          r_a16      <= cfg_16bits_ia;
          r_m_idx    <= '0;
          r_n_idx    <= '0;
          r_job_err  <= w_zero;
          r_sa_ready <= 1'b0;
          if (w_zero) begin
            r_state    <= DONE;
            r_job_done <= 1'b1;
          end else begin
            r_state <= ISSUE;
            r_valid <= 1'b1;
          end
        end
        ISSUE: if (tile.tile_ready) begin
          r_valid <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: if (tile.tile_done) begin
          if (w_last) begin
            r_state    <= DONE;
            r_job_done <= 1'b1;
          end else begin
            r_state <= ISSUE;
            r_valid <= 1'b1;
            if (w_last_col) begin
              r_n_idx <= '0;
              r_m_idx <= r_m_idx + W_TM;
            end else begin
              r_n_idx <= r_n_idx + W_TN;
            end
          end
        end
        DONE: begin
          r_job_done <= 1'b0;
          r_sa_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_cmd        = '0;
    w_cmd.a_addr = w_a_ptr;
    w_cmd.b_addr = w_b_ptr;
    w_cmd.c_addr = w_c_ptr;
    w_cmd.rows   = (w_m_rem > W_TM) ? W_TM : w_m_rem;
    w_cmd.cols   = (w_n_rem > W_TN) ? W_TN : w_n_rem;
    w_cmd.k      = r_k;
    w_cmd.a16    = r_a16;
    w_cmd.last   = r_valid && w_last;
  end

  assign tile.tile_valid  = r_valid;
  assign tile.tile_a_addr = w_cmd.a_addr;
  assign tile.tile_b_addr = w_cmd.b_addr;
  assign tile.tile_c_addr = w_cmd.c_addr;
  assign tile.tile_rows   = w_cmd.rows;
  assign tile.tile_cols   = w_cmd.cols;
  assign tile.tile_k      = w_cmd.k;
  assign tile.tile_a16    = w_cmd.a16;
  assign tile.tile_last   = w_cmd.last;
  assign sa_ready         = r_sa_ready;
  assign job_done         = r_job_done;
  assign job_err          = r_job_err;

`ifdef DSA_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_tiles;

  // counters restart on an accepted start and freeze in IDLE for readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else if (w_start) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else begin
      if ((r_state != IDLE) && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (r_valid && tile.tile_ready && (r_perf_tiles != '1)) r_perf_tiles <= r_perf_tiles + 16'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_tiles  = r_perf_tiles;
`endif
endmodule
